// File: rtl/ladybird_axi_ram.sv
// AXI4 responder RAM for the data-side port: single-beat and INCR burst accesses,
// one transaction at a time. Synchronous-read storage with byte-strobed writes.
module ladybird_axi_ram #(
   parameter int AXI_DATA_W = 32,
   parameter int DEPTH_W    = 12,
   parameter int ADDR_W     = 32,
   parameter int ID_W       = 4,
   parameter     INIT_FILE  = ""
) (
   input  logic                    clk_i,
   input  logic                    nrst_i,
   // write address
   input  logic [ID_W-1:0]         awid_i,
   input  logic [ADDR_W-1:0]       awaddr_i,
   input  logic [7:0]              awlen_i,
   input  logic [2:0]              awsize_i,
   input  logic [1:0]              awburst_i,
   input  logic                    awvalid_i,
   output logic                    awready_o,
   // write data
   input  logic [AXI_DATA_W-1:0]   wdata_i,
   input  logic [AXI_DATA_W/8-1:0] wstrb_i,
   input  logic                    wlast_i,
   input  logic                    wvalid_i,
   output logic                    wready_o,
   // write response
   output logic [ID_W-1:0]         bid_o,
   output logic [1:0]              bresp_o,
   output logic                    bvalid_o,
   input  logic                    bready_i,
   // read address
   input  logic [ID_W-1:0]         arid_i,
   input  logic [ADDR_W-1:0]       araddr_i,
   input  logic [7:0]              arlen_i,
   input  logic [2:0]              arsize_i,
   input  logic [1:0]              arburst_i,
   input  logic                    arvalid_i,
   output logic                    arready_o,
   // read data
   output logic [ID_W-1:0]         rid_o,
   output logic [AXI_DATA_W-1:0]   rdata_o,
   output logic [1:0]              rresp_o,
   output logic                    rlast_o,
   output logic                    rvalid_o,
   input  logic                    rready_i
);

   // state  | meaning
   // IDLE   | arbitrate between AW and AR
   // WBEAT  | accept W beats, write RAM
   // WRESP  | present B response until bready
   // RBEAT  | stream R beats from RAM
   typedef enum logic [1:0] {S_IDLE, S_WBEAT, S_WRESP, S_RBEAT} state_t;

   localparam int         STRB_W      = AXI_DATA_W / 8;
   localparam int         OFF         = $clog2(STRB_W);
   localparam logic [2:0] OFF_SZ      = 3'(OFF);
   localparam logic       GNT_READ    = 1'b0;
   localparam logic       GNT_WRITE   = 1'b1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   logic [AXI_DATA_W-1:0] mem_q [0:(2**DEPTH_W)-1];

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [7:0]            beat_q, beat_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  first_q, first_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rlast_q, rlast_d;
   logic [AXI_DATA_W-1:0] rdata_q;

   logic                  aw_take, ar_take, r_hs;
   logic                  wr_en, rd_issue;
   logic [2:0]            eff_size;
   logic [ADDR_W-1:0]     addr_nxt;
   logic [7:0]            beat_inc;
   logic [DEPTH_W-1:0]    widx;

   // Oversized transfers step by the bus width; WRAP is handled as INCR.
   assign eff_size = (size_q > OFF_SZ) ? OFF_SZ : size_q;
   assign addr_nxt = (burst_q == BURST_FIXED) ? addr_q : addr_q + (ADDR_W'(1) << eff_size);
   assign beat_inc = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
   assign widx     = addr_q[DEPTH_W+OFF-1:OFF];
   assign r_hs     = rvalid_q & rready_i;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      beat_d    = beat_q;
      bresp_d   = bresp_q;
      first_d   = first_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      aw_take   = 1'b0;
      ar_take   = 1'b0;
      wr_en     = 1'b0;
      rd_issue  = 1'b0;
      wready_o  = 1'b0;
      bvalid_o  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            aw_take = awvalid_i & (~arvalid_i | (grant_q == GNT_READ));
            ar_take = arvalid_i & ~aw_take;
            if (aw_take) begin
               id_d    = awid_i;
               addr_d  = awaddr_i;
               len_d   = awlen_i;
               size_d  = awsize_i;
               burst_d = awburst_i;
               beat_d  = 8'd0;
               grant_d = GNT_WRITE;
               state_d = S_WBEAT;
            end else if (ar_take) begin
               id_d    = arid_i;
               addr_d  = araddr_i;
               len_d   = arlen_i;
               size_d  = arsize_i;
               burst_d = arburst_i;
               beat_d  = 8'd0;
               grant_d = GNT_READ;
               first_d = 1'b1;
               state_d = S_RBEAT;
            end
         end
         S_WBEAT: begin
            wready_o = 1'b1;
            if (wvalid_i) begin
               wr_en  = 1'b1;
               addr_d = addr_nxt;
               beat_d = beat_inc;
               if (wlast_i) begin
                  bresp_d = (beat_q == len_q) ? RESP_OKAY : RESP_SLVERR;
                  state_d = S_WRESP;
               end
            end
         end
         S_WRESP: begin
            bvalid_o = 1'b1;
            if (bready_i) state_d = S_IDLE;
         end
         S_RBEAT: begin
            // The next RAM read is launched in the same cycle as the R handshake.
            if (r_hs & rlast_q) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               state_d  = S_IDLE;
            end else if (first_q | r_hs) begin
               rd_issue = 1'b1;
               first_d  = 1'b0;
               rvalid_d = 1'b1;
               rlast_d  = (beat_q == len_q);
               addr_d   = addr_nxt;
               beat_d   = beat_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign awready_o = aw_take;
   assign arready_o = ar_take;
   assign bid_o     = id_q;
   assign bresp_o   = bresp_q;
   assign rid_o     = id_q;
   assign rdata_o   = rdata_q;
   assign rresp_o   = RESP_OKAY;
   assign rlast_o   = rlast_q;
   assign rvalid_o  = rvalid_q;

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q  <= S_IDLE;
         grant_q  <= GNT_READ;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         bresp_q  <= RESP_OKAY;
         first_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         beat_q   <= beat_d;
         bresp_q  <= bresp_d;
         first_q  <= first_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
         if (rd_issue) rdata_q <= mem_q[widx];
      end
   end

   // Storage is deliberately left out of reset so contents survive nrst.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_i[b]) mem_q[widx][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

endmodule
